// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - receive-only PS/2 keyboard decoder: synchroniser, glitch filter, frame FSM
module ps2_keyboard #(
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] kb_data,
   output logic       kb_hit,
   output logic       kb_error
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_clk_filt, r_dat_filt, r_clk_prev;
   logic [3:0]    r_clk_cnt, r_dat_cnt;
   logic          r_fall, r_bit;
   state_t        r_state;
   logic [2:0]    r_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [TW-1:0] r_tmo;
   logic          w_fall;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // A line level flips only after FILTER consecutive disagreeing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_clk_filt <= 1'b1;
         r_dat_filt <= 1'b1;
         r_clk_cnt  <= 4'd0;
         r_dat_cnt  <= 4'd0;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_prev <= r_clk_filt;
         if (r_clk_s2 != r_clk_filt) begin
            if (r_clk_cnt == 4'(FILTER - 1)) begin
               r_clk_filt <= r_clk_s2;
               r_clk_cnt  <= 4'd0;
            end else begin
               r_clk_cnt <= r_clk_cnt + 4'd1;
            end
         end else begin
            r_clk_cnt <= 4'd0;
         end
         if (r_dat_s2 != r_dat_filt) begin
            if (r_dat_cnt == 4'(FILTER - 1)) begin
               r_dat_filt <= r_dat_s2;
               r_dat_cnt  <= 4'd0;
            end else begin
               r_dat_cnt <= r_dat_cnt + 4'd1;
            end
         end else begin
            r_dat_cnt <= 4'd0;
         end
      end
   end

   assign w_fall = r_clk_prev & ~r_clk_filt;

   // Bit value is captured in the falling-edge cycle and handed to the FSM with the edge flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fall <= 1'b0;
         r_bit  <= 1'b1;
      end else begin
         r_fall <= w_fall;
         r_bit  <= r_dat_filt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 3'd0;
         r_shift  <= 8'h00;
         r_parity <= 1'b0;
         r_tmo    <= '0;
         kb_data  <= 8'h00;
         kb_hit   <= 1'b0;
         kb_error <= 1'b0;
      end else begin
         kb_hit   <= 1'b0;
         kb_error <= 1'b0;
         if (r_state == S_IDLE || r_fall)
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + TW'(1);

         case (r_state)
            S_IDLE: begin
               if (r_fall && !r_bit) begin
                  r_state <= S_DATA;
                  r_cnt   <= 3'd0;
               end
            end
            S_DATA: begin
               if (r_fall) begin
                  r_shift <= {r_bit, r_shift[7:1]};
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7)
                     r_state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (r_fall) begin
                  r_parity <= r_bit;
                  r_state  <= S_STOP;
               end
            end
            S_STOP: begin
               if (r_fall) begin
                  r_state <= S_IDLE;
                  if ((^{r_shift, r_parity}) && r_bit) begin
                     kb_data <= r_shift;
                     kb_hit  <= 1'b1;
                  end else begin
                     kb_error <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A stalled partial frame is dropped silently.
         if (r_state != S_IDLE && !r_fall && r_tmo == TW'(TIMEOUT)) begin
            r_state <= S_IDLE;
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
         end
      end
   end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 The module SHALL have parameter FILTER, default 4, giving the number of consecutive identical synchronised samples needed to change a filtered PS/2 line level (range 1..15).
REQ-002 The module SHALL have parameter TIMEOUT, default 50000, giving the number of clock cycles without a filtered ps2_clk falling edge after which a partial frame is abandoned (1 ms at 50 MHz).
REQ-003 Port clock SHALL be an input, 1 bit: the single clock for all logic, 50 MHz nominal.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port ps2_clk SHALL be an input, 1 bit: PS/2 clock line, asynchronous, idle high.
REQ-006 Port ps2_data SHALL be an input, 1 bit: PS/2 data line, asynchronous, idle high.
REQ-007 Port kb_data SHALL be an output, 8 bits: last correctly received byte, held stable between frames.
REQ-008 Port kb_hit SHALL be an output, 1 bit: one-cycle pulse marking that kb_data has been updated with a new byte.
REQ-009 Port kb_error SHALL be an output, 1 bit: one-cycle pulse on a parity or stop-bit failure.

Function
REQ-010 The design SHALL pass ps2_clk and ps2_data through two flip-flops each before any other use.
REQ-011 The filtered level of each line SHALL change only after FILTER consecutive identical synchronised samples that differ from the current filtered level.
REQ-012 A falling edge SHALL be the cycle in which the filtered ps2_clk changes from 1 to 0; each bit SHALL be sampled from filtered ps2_data in that same cycle.
REQ-013 The state machine SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-014 In IDLE, a falling edge with data 0 SHALL move to DATA and clear the bit counter; a falling edge with data 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-015 In DATA, 8 bits SHALL be shifted in LSB first; after the 8th bit the FSM SHALL move to PARITY.
REQ-016 In PARITY, the sampled bit SHALL be stored and the FSM SHALL move to STOP.
REQ-017 A frame SHALL be valid when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-018 In STOP, the FSM SHALL return to IDLE on the falling edge.
REQ-019 In STOP, when the frame is valid and the stop bit is 1, kb_data SHALL load the byte and kb_hit SHALL be 1 for exactly the next cycle.
REQ-020 In STOP, on bad parity or a stop bit of 0, kb_error SHALL pulse for 1 cycle, kb_data SHALL stay unchanged and kb_hit SHALL stay 0.
REQ-021 Latency SHALL be exactly FILTER+3 clock cycles from the first clock edge that samples ps2_clk low on the stop bit to kb_hit going high.
REQ-022 kb_hit and kb_error SHALL never be asserted in the same cycle, and neither SHALL be asserted for longer than 1 cycle.
REQ-023 A timeout counter SHALL clear on every falling edge and whenever the FSM is in IDLE, and SHALL increment in every other cycle.
REQ-024 When the timeout counter reaches TIMEOUT outside IDLE, the FSM SHALL return to IDLE, discard the partial byte, and assert neither kb_hit nor kb_error.
REQ-025 Back-to-back frames with no idle gap SHALL each produce a kb_hit.
REQ-026 The block SHALL NOT drive the PS/2 lines; it is receive-only.

Reset
REQ-027 While reset is 1, the FSM SHALL be IDLE, and the bit counter, shift register and timeout counter SHALL be 0.
REQ-028 While reset is 1, kb_data SHALL be 8'h00 and kb_hit and kb_error SHALL be 0.
REQ-029 While reset is 1, both synchroniser stages and both filtered levels SHALL be 1.
REQ-030 A reset asserted mid-frame SHALL abandon the frame with no pulse.
REQ-031 After reset, the first byte SHALL be received only from the next start bit.

Verification
REQ-032 The bench SHALL send frame 0x1C with parity 0 and stop 1 -> kb_data=8'h1C, a single kb_hit exactly FILTER+3 cycles after the stop-bit clock falls, and kb_error=0.
REQ-033 The bench SHALL send 0xF0 (parity 1) followed immediately by 0x1C (parity 0) -> two kb_hit pulses, with kb_data reading 8'hF0 and then 8'h1C.
REQ-034 The bench SHALL send 0x1C with parity 1 -> one kb_error pulse, no kb_hit, and kb_data keeping its previous value.
REQ-035 The bench SHALL send a start bit plus 4 data bits, stall for TIMEOUT+10 cycles, then send 0x3F (parity 1) -> no pulses during the stall, then kb_data=8'h3F with one kb_hit.
REQ-036 The bench SHALL inject 2-cycle glitches on ps2_clk with FILTER=4 -> no bits captured; it SHALL then assert reset for 1 cycle mid-frame -> no pulses, and kb_data=8'h00.
REQ-037 The bench SHALL send 0x1C with stop bit 0 -> kb_error pulse, no kb_hit, and the FSM back in IDLE.
